// File: rtl/fifo36_pkg.sv
// Shared definitions for the fifo36 stream blocks: line bit positions,
// route codes and the splitter FSM encoding.
package fifo36_pkg;

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;
  localparam int OCC_MSB = 35;
  localparam int OCC_LSB = 34;

  localparam logic [1:0] ROUTE_P0   = 2'd0;
  localparam logic [1:0] ROUTE_P1   = 2'd1;
  localparam logic [1:0] ROUTE_P2   = 2'd2;
  localparam logic [1:0] ROUTE_DROP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

endpackage

// File: rtl/fifo36_three_way_split_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_inc,
  output logic [15:0] o_cnt
);

  logic [15:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fifo36_three_way_split.sv
// Routes fifo36 packets to one of three output ports by a 2-bit header field,
// optionally discarding route 3, through a single registered output stage.
//
// Handshake: on every port a line moves on the rising edge where the source's
// src_rdy and the sink's dst_rdy are both high; src_rdy never waits on dst_rdy.
module fifo36_three_way_split
  import fifo36_pkg::*;
#(
  parameter int SEL_LSB = 16,
  parameter bit DROP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic [35:0] data_i,
  input  logic        src_rdy_i,
  output logic        dst_rdy_o,
  output logic [35:0] data0_o,
  output logic [35:0] data1_o,
  output logic [35:0] data2_o,
  output logic        src0_rdy_o,
  output logic        src1_rdy_o,
  output logic        src2_rdy_o,
  input  logic        dst0_rdy_i,
  input  logic        dst1_rdy_i,
  input  logic        dst2_rdy_i,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [15:0] pkt_cnt2,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt,
  output state_e      dbg_state_o
);

  logic [1:0]  r_sync;
  state_e      r_state;
  logic [1:0]  r_pkt_port;
  logic        r_out_vld;
  logic [1:0]  r_out_port;
  logic [35:0] r_out_data;

  state_e      w_state_nxt;
  logic [1:0]  w_pkt_port_nxt;
  logic        w_load;
  logic [1:0]  w_load_port;
  logic        w_err_inc;
  logic        w_drop_inc;
  logic        w_sel_rdy;
  logic        w_drain;
  logic        w_acc;
  logic        w_sof;
  logic        w_eof;
  logic [1:0]  w_route;
  logic [2:0]  w_pkt_inc;

  // Input lines are ignored until reset release has passed two flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b00;
    else          r_sync <= {r_sync[0], 1'b1};
  end

  always_comb begin
    case (r_out_port)
      ROUTE_P0: w_sel_rdy = dst0_rdy_i;
      ROUTE_P1: w_sel_rdy = dst1_rdy_i;
      default:  w_sel_rdy = dst2_rdy_i;
    endcase
  end

  assign dst_rdy_o = !r_out_vld | w_sel_rdy;
  assign w_drain   = r_out_vld & w_sel_rdy;
  assign w_acc     = src_rdy_i & dst_rdy_o & r_sync[1];
  assign w_sof     = data_i[SOF_BIT];
  assign w_eof     = data_i[EOF_BIT];
  assign w_route   = data_i[SEL_LSB +: 2];

  always_comb begin
    w_state_nxt    = r_state;
    w_pkt_port_nxt = r_pkt_port;
    w_load         = 1'b0;
    w_load_port    = r_pkt_port;
    w_err_inc      = 1'b0;
    w_drop_inc     = 1'b0;
    if (w_acc) begin
      if (w_sof) begin
        // A header inside an open packet truncates it and starts a new one.
        if (r_state != ST_IDLE) w_err_inc = 1'b1;
        if ((w_route == ROUTE_DROP) && DROP_EN) begin
          w_drop_inc  = w_eof;
          w_state_nxt = w_eof ? ST_IDLE : ST_DROP;
        end else begin
          w_load         = 1'b1;
          w_load_port    = (w_route == ROUTE_DROP) ? ROUTE_P2 : w_route;
          w_pkt_port_nxt = w_load_port;
          w_state_nxt    = w_eof ? ST_IDLE : ST_FWD;
        end
      end else begin
        case (r_state)
          ST_FWD: begin
            w_load = 1'b1;
            if (w_eof) w_state_nxt = ST_IDLE;
          end
          ST_DROP: begin
            if (w_eof) begin
              w_drop_inc  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end
          default: w_err_inc = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_pkt_port <= ROUTE_P0;
      r_out_vld  <= 1'b0;
      r_out_port <= ROUTE_P0;
      r_out_data <= '0;
    end else if (clear) begin
      r_state    <= ST_IDLE;
      r_pkt_port <= ROUTE_P0;
      r_out_vld  <= 1'b0;
      r_out_port <= ROUTE_P0;
      r_out_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pkt_port <= w_pkt_port_nxt;
      // w_load implies the register is empty or draining this cycle.
      if (w_load) begin
        r_out_vld  <= 1'b1;
        r_out_port <= w_load_port;
        r_out_data <= data_i;
      end else if (w_drain) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign data0_o     = r_out_data;
  assign data1_o     = r_out_data;
  assign data2_o     = r_out_data;
  assign src0_rdy_o  = r_out_vld & (r_out_port == ROUTE_P0);
  assign src1_rdy_o  = r_out_vld & (r_out_port == ROUTE_P1);
  assign src2_rdy_o  = r_out_vld & (r_out_port == ROUTE_P2);
  assign dbg_state_o = r_state;

  assign w_pkt_inc[0] = w_drain & r_out_data[EOF_BIT] & (r_out_port == ROUTE_P0);
  assign w_pkt_inc[1] = w_drain & r_out_data[EOF_BIT] & (r_out_port == ROUTE_P1);
  assign w_pkt_inc[2] = w_drain & r_out_data[EOF_BIT] & (r_out_port == ROUTE_P2);

  sat_cnt16 u_pkt_cnt0 (.i_clk(clk), .i_rst_n(reset_n), .i_clear(clear), .i_inc(w_pkt_inc[0]), .o_cnt(pkt_cnt0));
  sat_cnt16 u_pkt_cnt1 (.i_clk(clk), .i_rst_n(reset_n), .i_clear(clear), .i_inc(w_pkt_inc[1]), .o_cnt(pkt_cnt1));
  sat_cnt16 u_pkt_cnt2 (.i_clk(clk), .i_rst_n(reset_n), .i_clear(clear), .i_inc(w_pkt_inc[2]), .o_cnt(pkt_cnt2));
  sat_cnt16 u_drop_cnt (.i_clk(clk), .i_rst_n(reset_n), .i_clear(clear), .i_inc(w_drop_inc),   .o_cnt(drop_cnt));
  sat_cnt16 u_err_cnt  (.i_clk(clk), .i_rst_n(reset_n), .i_clear(clear), .i_inc(w_err_inc),    .o_cnt(err_cnt));

endmodule

// File: tb/tb_fifo36_three_way_split.sv
// Directed scenarios for fifo36_three_way_split; expected lines are queued at
// acceptance and popped by an output monitor on the falling clock edge.
module tb_fifo36_three_way_split;
  import fifo36_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        clear;
  logic [35:0] data_i;
  logic        src_rdy_i;
  logic        dst_rdy_o;
  logic [35:0] data0_o, data1_o, data2_o;
  logic        src0_rdy_o, src1_rdy_o, src2_rdy_o;
  logic        dst0_rdy_i, dst1_rdy_i, dst2_rdy_i;
  logic [15:0] pkt_cnt0, pkt_cnt1, pkt_cnt2, drop_cnt, err_cnt;
  state_e      dbg_state;

  logic [37:0] exp_q[$];
  int          n_checks;
  int          n_pass;

  fifo36_three_way_split #(.SEL_LSB(16), .DROP_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o),
    .data0_o(data0_o), .data1_o(data1_o), .data2_o(data2_o),
    .src0_rdy_o(src0_rdy_o), .src1_rdy_o(src1_rdy_o), .src2_rdy_o(src2_rdy_o),
    .dst0_rdy_i(dst0_rdy_i), .dst1_rdy_i(dst1_rdy_i), .dst2_rdy_i(dst2_rdy_i),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .pkt_cnt2(pkt_cnt2),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [35:0] ln(input logic sof, input logic eof,
                                     input logic [1:0] occ, input logic [31:0] w);
    return {occ, eof, sof, w};
  endfunction

  // driver: present a line, wait for acceptance, queue its expected output
  task automatic send(input logic [35:0] d, input int exp_port, output int waits);
    data_i    = d;
    src_rdy_i = 1'b1;
    waits     = 0;
    @(negedge clk);
    while (!dst_rdy_o && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!dst_rdy_o) check("accept_timeout", 64'd0, 64'd1);
    else if (exp_port >= 0) exp_q.push_back({exp_port[1:0], d});
    @(posedge clk);
    #1;
    src_rdy_i = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin : monitor
    int          n_src;
    logic [37:0] e;
    if (reset_n && !clear) begin
      n_src = int'(src0_rdy_o) + int'(src1_rdy_o) + int'(src2_rdy_o);
      if (n_src != 0) check("one_port_active", 64'(n_src), 64'd1);
      for (int p = 0; p < 3; p++) begin
        if ((p == 0 && src0_rdy_o && dst0_rdy_i) ||
            (p == 1 && src1_rdy_o && dst1_rdy_i) ||
            (p == 2 && src2_rdy_o && dst2_rdy_i)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'(p), 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            check("out_port", 64'(p), 64'(e[37:36]));
            check("out_data", 64'(p == 0 ? data0_o : (p == 1 ? data1_o : data2_o)), 64'(e[35:0]));
          end
        end
      end
    end
  end

  initial begin : stim
    int w;
    int tot;
    logic [35:0] l1;
    n_checks = 0;
    n_pass   = 0;
    reset_n = 1'b0; clear = 1'b0; data_i = '0; src_rdy_i = 1'b0;
    dst0_rdy_i = 1'b1; dst1_rdy_i = 1'b1; dst2_rdy_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dst_rdy", 64'(dst_rdy_o), 64'd1);
    check("rst_src_rdy", 64'({src0_rdy_o, src1_rdy_o, src2_rdy_o}), 64'd0);
    check("rst_data0", 64'(data0_o), 64'd0);
    check("rst_counters", {pkt_cnt0, pkt_cnt1, pkt_cnt2, drop_cnt}, 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 3-line packet to port 1
    tot = 0;
    send(ln(1, 0, 2'd0, 32'h0001_BEEF), 1, w); tot += w;
    send(ln(0, 0, 2'd0, 32'h1111_1111), 1, w); tot += w;
    send(ln(0, 1, 2'd2, 32'h2222_2222), 1, w); tot += w;
    settle();
    check("p1_no_stall", 64'(tot), 64'd0);
    check("p1_pkt_cnt1", 64'(pkt_cnt1), 64'd1);
    check("p1_pkt_cnt0", 64'(pkt_cnt0), 64'd0);

    // back-to-back single-line packets 0, 2, 0
    tot = 0;
    send(ln(1, 1, 2'd1, 32'h0000_0A00), 0, w); tot += w;
    send(ln(1, 1, 2'd3, 32'h0002_0B00), 2, w); tot += w;
    send(ln(1, 1, 2'd0, 32'h0000_0C00), 0, w); tot += w;
    settle();
    check("b2b_no_stall", 64'(tot), 64'd0);
    check("b2b_pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    check("b2b_pkt_cnt2", 64'(pkt_cnt2), 64'd1);

    // route-3 packet dropped
    tot = 0;
    send(ln(1, 0, 2'd0, 32'h0003_0000), -1, w); tot += w;
    send(ln(0, 0, 2'd0, 32'hAAAA_0001), -1, w); tot += w;
    send(ln(0, 0, 2'd0, 32'hAAAA_0002), -1, w); tot += w;
    send(ln(0, 1, 2'd1, 32'hAAAA_0003), -1, w); tot += w;
    settle();
    check("drop_rdy_held", 64'(tot), 64'd0);
    check("drop_cnt", 64'(drop_cnt), 64'd1);
    check("drop_state", 64'(dbg_state), 64'(ST_IDLE));

    // port 2 sink stalls 5 cycles mid-packet
    l1 = ln(0, 0, 2'd0, 32'h5A5A_0001);
    send(ln(1, 0, 2'd0, 32'h0002_1234), 2, w);
    send(l1, 2, w);
    dst2_rdy_i = 1'b0;
    data_i     = ln(0, 0, 2'd0, 32'h5A5A_0002);
    src_rdy_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_dst_rdy", 64'(dst_rdy_o), 64'd0);
      check("stall_data_stable", 64'(data2_o), 64'(l1));
      check("stall_src2_rdy", 64'(src2_rdy_o), 64'd1);
    end
    @(posedge clk);
    #1;
    dst2_rdy_i = 1'b1;
    send(ln(0, 0, 2'd0, 32'h5A5A_0002), 2, w);
    send(ln(0, 1, 2'd3, 32'h5A5A_0003), 2, w);
    settle();
    check("stall_pkt_cnt2", 64'(pkt_cnt2), 64'd2);

    // stray line in IDLE, then header inside an open packet
    send(ln(0, 0, 2'd0, 32'hDEAD_0000), -1, w);
    send(ln(1, 0, 2'd0, 32'h0000_5555), 0, w);
    send(ln(0, 0, 2'd0, 32'h0000_5556), 0, w);
    send(ln(1, 1, 2'd2, 32'h0002_6666), 2, w);
    settle();
    check("err_cnt", 64'(err_cnt), 64'd2);
    check("err_pkt_cnt2", 64'(pkt_cnt2), 64'd3);
    check("err_pkt_cnt0", 64'(pkt_cnt0), 64'd2);

    // asynchronous reset with a line held on port 1
    dst1_rdy_i = 1'b0;
    send(ln(1, 0, 2'd0, 32'h0001_0000), 1, w);
    check("held_src1_rdy", 64'(src1_rdy_o), 64'd1);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("arst_src1_rdy", 64'(src1_rdy_o), 64'd0);
    check("arst_data1", 64'(data1_o), 64'd0);
    check("arst_dst_rdy", 64'(dst_rdy_o), 64'd1);
    check("arst_counters", {pkt_cnt0, pkt_cnt2, drop_cnt, err_cnt}, 64'd0);
    dst1_rdy_i = 1'b1;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(ln(1, 1, 2'd0, 32'h0002_7777), 2, w);
    settle();
    check("post_rst_pkt_cnt2", 64'(pkt_cnt2), 64'd1);

    // synchronous clear with a line held on port 0
    dst0_rdy_i = 1'b0;
    send(ln(1, 0, 2'd0, 32'h0000_8888), 0, w);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_q.delete();
    dst0_rdy_i = 1'b1;
    check("clr_src0_rdy", 64'(src0_rdy_o), 64'd0);
    check("clr_dst_rdy", 64'(dst_rdy_o), 64'd1);
    check("clr_pkt_cnt2", 64'(pkt_cnt2), 64'd0);
    check("clr_state", 64'(dbg_state), 64'(ST_IDLE));
    send(ln(0, 1, 2'd0, 32'h0000_9999), -1, w);
    settle();
    check("clr_err_cnt", 64'(err_cnt), 64'd1);

    // saturation of pkt_cnt0
    for (int i = 0; i < 65535; i++) send(ln(1, 1, 2'd0, 32'(i) & 32'hFFFC_FFFF), 0, w);
    settle();
    check("sat_reach", 64'(pkt_cnt0), 64'hFFFF);
    send(ln(1, 1, 2'd0, 32'h0000_0001), 0, w);
    settle();
    check("sat_hold", 64'(pkt_cnt0), 64'hFFFF);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
